// File: rtl/uart_axil_pkg.sv
// Shared types and constants for the UART-to-AXI4-Lite bridge.
package uart_axil_pkg;

    typedef enum logic [2:0] {
        IDLE,
        GET_ADDR,
        GET_DATA,
        AXI_WR,
        AXI_B,
        AXI_AR,
        AXI_R,
        SEND_RESP
    } state_t;

    localparam logic [7:0] OPC_WRITE = 8'h57;
    localparam logic [7:0] OPC_READ  = 8'h52;

    localparam int RESP_WR_BYTES  = 1;
    localparam int RESP_RD_BYTES  = 5;
    localparam int RESP_MAX_BYTES = 5;

endpackage

// File: rtl/uart_axil_resp_ser.sv
// Response byte serialiser: loads up to RESP_MAX_BYTES left-justified bytes
// and hands them to the UART transmitter one tx_start/tx_done handshake at a time.
module uart_axil_resp_ser
    import uart_axil_pkg::*;
(
    input  logic                        clk,
    input  logic                        nrst,
    input  logic                        load,
    input  logic [8*RESP_MAX_BYTES-1:0] load_bytes,
    input  logic [2:0]                  load_count,
    input  logic                        tx_done,
    output logic [7:0]                  tx_data,
    output logic                        tx_start,
    output logic                        last_done
);

    logic [8*RESP_MAX_BYTES-1:0] shreg;
    logic [2:0]                  remaining;

    // tx_start stays high across byte boundaries; the next byte appears in the tx_done cycle
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            shreg     <= '0;
            remaining <= '0;
            tx_start  <= 1'b0;
        end else if (load) begin
            shreg     <= load_bytes;
            remaining <= load_count;
            tx_start  <= 1'b1;
        end else if (tx_start && tx_done) begin
            if (remaining > 3'd1) begin
                shreg     <= {shreg[8*RESP_MAX_BYTES-9:0], 8'h00};
                remaining <= remaining - 3'd1;
            end else begin
                remaining <= '0;
                tx_start  <= 1'b0;
            end
        end
    end

    assign tx_data   = shreg[8*RESP_MAX_BYTES-1 -: 8];
    assign last_done = tx_start && tx_done && (remaining == 3'd1);

endmodule

// File: rtl/uart_axil_master.sv
// UART command-frame decoder driving a single AXI4-Lite master port.
// Optional inter-byte timeout enabled by defining UART_AXIL_TIMEOUT_EN.
module uart_axil_master
    import uart_axil_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 5_000_000
) (
    input  logic                  clk,
    input  logic                  nrst,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    input  logic                  rx_error,
    output logic [7:0]            tx_data,
    output logic                  tx_start,
    input  logic                  tx_done,
    output logic                  busy,
    output logic [ADDR_WIDTH-1:0] m_axi_awaddr,
    output logic [2:0]            m_axi_awprot,
    output logic                  m_axi_awvalid,
    input  logic                  m_axi_awready,
    output logic [31:0]           m_axi_wdata,
    output logic [3:0]            m_axi_wstrb,
    output logic                  m_axi_wvalid,
    input  logic                  m_axi_wready,
    input  logic [1:0]            m_axi_bresp,
    input  logic                  m_axi_bvalid,
    output logic                  m_axi_bready,
    output logic [ADDR_WIDTH-1:0] m_axi_araddr,
    output logic [2:0]            m_axi_arprot,
    output logic                  m_axi_arvalid,
    input  logic                  m_axi_arready,
    input  logic [31:0]           m_axi_rdata,
    input  logic [1:0]            m_axi_rresp,
    input  logic                  m_axi_rvalid,
    output logic                  m_axi_rready
);

    state_t      state;
    logic [1:0]  byte_cnt;
    logic        is_write;
    logic [31:0] addr_q;
    logic [31:0] data_q;
    logic        timeout_hit;

    logic                        resp_load;
    logic [8*RESP_MAX_BYTES-1:0] resp_bytes;
    logic [2:0]                  resp_count;
    logic                        resp_done;

`ifdef UART_AXIL_TIMEOUT_EN
    logic [31:0] idle_cnt;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            idle_cnt <= '0;
        end else if (rx_valid || !(state == GET_ADDR || state == GET_DATA)) begin
            idle_cnt <= '0;
        end else begin
            idle_cnt <= idle_cnt + 32'd1;
        end
    end

    assign timeout_hit = (state == GET_ADDR || state == GET_DATA) && !rx_valid &&
                         (idle_cnt == 32'(TIMEOUT_CYCLES - 1));
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT_CYCLES == 0);
    assign timeout_hit    = 1'b0;
`endif

    // A timeout overrides whatever the frame decoder decided in the same cycle
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state         <= IDLE;
            byte_cnt      <= '0;
            is_write      <= 1'b0;
            addr_q        <= '0;
            data_q        <= '0;
            m_axi_awvalid <= 1'b0;
            m_axi_wvalid  <= 1'b0;
            m_axi_bready  <= 1'b0;
            m_axi_arvalid <= 1'b0;
            m_axi_rready  <= 1'b0;
            busy          <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (rx_valid && !rx_error && (rx_data == OPC_WRITE || rx_data == OPC_READ)) begin
                        is_write <= (rx_data == OPC_WRITE);
                        byte_cnt <= '0;
                        busy     <= 1'b1;
                        state    <= GET_ADDR;
                    end
                end
                GET_ADDR: begin
                    if (rx_valid && rx_error) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else if (rx_valid) begin
                        addr_q   <= {addr_q[23:0], rx_data};
                        byte_cnt <= byte_cnt + 2'd1;
                        if (byte_cnt == 2'd3) begin
                            if (is_write) begin
                                state <= GET_DATA;
                            end else begin
                                m_axi_arvalid <= 1'b1;
                                state         <= AXI_AR;
                            end
                        end
                    end
                end
                GET_DATA: begin
                    if (rx_valid && rx_error) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else if (rx_valid) begin
                        data_q   <= {data_q[23:0], rx_data};
                        byte_cnt <= byte_cnt + 2'd1;
                        if (byte_cnt == 2'd3) begin
                            m_axi_awvalid <= 1'b1;
                            m_axi_wvalid  <= 1'b1;
                            state         <= AXI_WR;
                        end
                    end
                end
                AXI_WR: begin
                    if (m_axi_awready) m_axi_awvalid <= 1'b0;
                    if (m_axi_wready)  m_axi_wvalid  <= 1'b0;
                    if ((!m_axi_awvalid || m_axi_awready) && (!m_axi_wvalid || m_axi_wready)) begin
                        m_axi_bready <= 1'b1;
                        state        <= AXI_B;
                    end
                end
                AXI_B: begin
                    if (m_axi_bvalid) begin
                        m_axi_bready <= 1'b0;
                        state        <= SEND_RESP;
                    end
                end
                AXI_AR: begin
                    if (m_axi_arready) begin
                        m_axi_arvalid <= 1'b0;
                        m_axi_rready  <= 1'b1;
                        state         <= AXI_R;
                    end
                end
                AXI_R: begin
                    if (m_axi_rvalid) begin
                        m_axi_rready <= 1'b0;
                        state        <= SEND_RESP;
                    end
                end
                SEND_RESP: begin
                    if (resp_done) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

            if (timeout_hit) begin
                busy  <= 1'b0;
                state <= IDLE;
            end
        end
    end

    assign m_axi_awaddr = addr_q[ADDR_WIDTH-1:0];
    assign m_axi_araddr = addr_q[ADDR_WIDTH-1:0];
    assign m_axi_wdata  = data_q;
    assign m_axi_awprot = 3'b000;
    assign m_axi_arprot = 3'b000;
    assign m_axi_wstrb  = 4'hF;

    assign resp_load  = (state == AXI_B && m_axi_bvalid && m_axi_bready) ||
                        (state == AXI_R && m_axi_rvalid && m_axi_rready);
    assign resp_bytes = (state == AXI_R) ? {6'b0, m_axi_rresp, m_axi_rdata}
                                         : {6'b0, m_axi_bresp, 32'h0};
    assign resp_count = (state == AXI_R) ? 3'(RESP_RD_BYTES) : 3'(RESP_WR_BYTES);

    uart_axil_resp_ser u_resp_ser (
        .clk        (clk),
        .nrst       (nrst),
        .load       (resp_load),
        .load_bytes (resp_bytes),
        .load_count (resp_count),
        .tx_done    (tx_done),
        .tx_data    (tx_data),
        .tx_start   (tx_start),
        .last_done  (resp_done)
    );

endmodule

// File: tb/tb_uart_axil_master.sv
// Directed self-checking bench for uart_axil_master (TIMEOUT_CYCLES=100;
// the timeout step follows UART_AXIL_TIMEOUT_EN when it is defined).
module tb_uart_axil_master;

    logic        clk;
    logic        nrst;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_error;
    logic [7:0]  tx_data;
    logic        tx_start;
    logic        tx_done;
    logic        busy;
    logic [31:0] awaddr;
    logic [2:0]  awprot;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [31:0] araddr;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;

    int vectors     = 0;
    int miscompares = 0;

    uart_axil_master #(
        .ADDR_WIDTH     (32),
        .TIMEOUT_CYCLES (100)
    ) dut (
        .clk           (clk),
        .nrst          (nrst),
        .rx_data       (rx_data),
        .rx_valid      (rx_valid),
        .rx_error      (rx_error),
        .tx_data       (tx_data),
        .tx_start      (tx_start),
        .tx_done       (tx_done),
        .busy          (busy),
        .m_axi_awaddr  (awaddr),
        .m_axi_awprot  (awprot),
        .m_axi_awvalid (awvalid),
        .m_axi_awready (awready),
        .m_axi_wdata   (wdata),
        .m_axi_wstrb   (wstrb),
        .m_axi_wvalid  (wvalid),
        .m_axi_wready  (wready),
        .m_axi_bresp   (bresp),
        .m_axi_bvalid  (bvalid),
        .m_axi_bready  (bready),
        .m_axi_araddr  (araddr),
        .m_axi_arprot  (arprot),
        .m_axi_arvalid (arvalid),
        .m_axi_arready (arready),
        .m_axi_rdata   (rdata),
        .m_axi_rresp   (rresp),
        .m_axi_rvalid  (rvalid),
        .m_axi_rready  (rready)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // One received byte: rx_valid high for exactly one cycle, returns 1 time unit after the capturing edge
    task automatic applyStimulus(input logic [7:0] b, input logic err);
        @(posedge clk);
        #1;
        rx_data  = b;
        rx_valid = 1'b1;
        rx_error = err;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        rx_error = 1'b0;
    endtask

    task automatic pulseTxDone();
        @(posedge clk);
        #1 tx_done = 1'b1;
        @(posedge clk);
        #1 tx_done = 1'b0;
    endtask

    task automatic doRead(input logic [31:0] addr, input logic [31:0] data, input logic [1:0] resp);
        logic [7:0] exp_bytes [5];
        applyStimulus(8'h52, 1'b0);
        checkOutput("rd_busy_accept", busy, 1);
        for (int i = 0; i < 4; i++) applyStimulus(addr[31-8*i -: 8], 1'b0);
        checkOutput("rd_arvalid", arvalid, 1);
        checkOutput("rd_araddr", araddr, addr);
        checkOutput("rd_arprot", arprot, 0);
        checkOutput("rd_rready_early", rready, 0);
        arready = 1'b1;
        @(posedge clk);
        #1 arready = 1'b0;
        checkOutput("rd_arvalid_drop", arvalid, 0);
        checkOutput("rd_rready", rready, 1);
        rvalid = 1'b1;
        rdata  = data;
        rresp  = resp;
        @(posedge clk);
        #1 rvalid = 1'b0;
        checkOutput("rd_rready_drop", rready, 0);
        exp_bytes = '{{6'b0, resp}, data[31:24], data[23:16], data[15:8], data[7:0]};
        for (int i = 0; i < 5; i++) begin
            checkOutput($sformatf("rd_tx_start%0d", i), tx_start, 1);
            checkOutput($sformatf("rd_byte%0d", i), tx_data, exp_bytes[i]);
            checkOutput($sformatf("rd_busy%0d", i), busy, 1);
            pulseTxDone();
        end
        checkOutput("rd_busy_end", busy, 0);
        checkOutput("rd_tx_start_end", tx_start, 0);
    endtask

    initial begin
        logic seen;
        clk = 0; nrst = 1;
        rx_data = 0; rx_valid = 0; rx_error = 0; tx_done = 0;
        awready = 0; wready = 0; bresp = 0; bvalid = 0;
        arready = 0; rdata = 0; rresp = 0; rvalid = 0;

        #2 nrst = 0;
        #1;
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_valids", {awvalid, wvalid, arvalid, bready, rready, tx_start}, 0);
        checkOutput("rst_awaddr", awaddr, 0);
        checkOutput("rst_wdata", wdata, 0);
        checkOutput("rst_tx_data", tx_data, 0);
        repeat (2) @(posedge clk);
        #1 nrst = 1;

        $display("[TB] single-cycle write");
        applyStimulus(8'h57, 1'b0);
        checkOutput("wr_busy_accept", busy, 1);
        applyStimulus(8'h00, 1'b0); applyStimulus(8'h00, 1'b0);
        applyStimulus(8'h10, 1'b0); applyStimulus(8'h04, 1'b0);
        checkOutput("wr_no_aw_before_data", awvalid, 0);
        applyStimulus(8'hDE, 1'b0); applyStimulus(8'hAD, 1'b0);
        applyStimulus(8'hBE, 1'b0); applyStimulus(8'hEF, 1'b0);
        checkOutput("wr_awvalid", awvalid, 1);
        checkOutput("wr_wvalid", wvalid, 1);
        checkOutput("wr_awaddr", awaddr, 32'h0000_1004);
        checkOutput("wr_wdata", wdata, 32'hDEAD_BEEF);
        checkOutput("wr_wstrb", wstrb, 4'hF);
        checkOutput("wr_awprot", awprot, 0);
        checkOutput("wr_bready_early", bready, 0);
        awready = 1; wready = 1;
        @(posedge clk);
        #1 awready = 0; wready = 0;
        checkOutput("wr_valids_drop", {awvalid, wvalid}, 0);
        checkOutput("wr_bready", bready, 1);
        bvalid = 1; bresp = 2'b00;
        @(posedge clk);
        #1 bvalid = 0;
        checkOutput("wr_bready_drop", bready, 0);
        checkOutput("wr_tx_start", tx_start, 1);
        checkOutput("wr_tx_byte", tx_data, 8'h00);
        pulseTxDone();
        checkOutput("wr_tx_start_end", tx_start, 0);
        checkOutput("wr_busy_end", busy, 0);

        $display("[TB] read with rresp=2");
        doRead(32'h0000_0020, 32'h1234_5678, 2'b10);

        $display("[TB] write with late wready");
        applyStimulus(8'h57, 1'b0);
        applyStimulus(8'h00, 1'b0); applyStimulus(8'h00, 1'b0);
        applyStimulus(8'h00, 1'b0); applyStimulus(8'h08, 1'b0);
        applyStimulus(8'h00, 1'b0); applyStimulus(8'h00, 1'b0);
        applyStimulus(8'h00, 1'b0); applyStimulus(8'h01, 1'b0);
        checkOutput("lw_awaddr", awaddr, 32'h0000_0008);
        checkOutput("lw_wdata", wdata, 32'h0000_0001);
        awready = 1;
        @(posedge clk);
        #1 awready = 0;
        checkOutput("lw_aw_drop", awvalid, 0);
        checkOutput("lw_w_held", wvalid, 1);
        checkOutput("lw_bready_wait0", bready, 0);
        @(posedge clk);
        #1;
        checkOutput("lw_w_held2", wvalid, 1);
        checkOutput("lw_bready_wait1", bready, 0);
        @(posedge clk);
        #1 wready = 1;
        checkOutput("lw_bready_wait2", bready, 0);
        @(posedge clk);
        #1 wready = 0;
        checkOutput("lw_w_drop", wvalid, 0);
        checkOutput("lw_bready", bready, 1);
        bvalid = 1; bresp = 2'b01;
        @(posedge clk);
        #1 bvalid = 0;
        checkOutput("lw_tx_byte", tx_data, 8'h01);
        checkOutput("lw_tx_start", tx_start, 1);
        pulseTxDone();
        checkOutput("lw_busy_end", busy, 0);

        $display("[TB] bad opcode and framing error");
        applyStimulus(8'h41, 1'b0);
        checkOutput("bad_opc_busy", busy, 0);
        applyStimulus(8'h52, 1'b0);
        checkOutput("abort_busy_accept", busy, 1);
        applyStimulus(8'h00, 1'b1);
        checkOutput("abort_busy", busy, 0);
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1 seen = seen | arvalid | tx_start;
        end
        checkOutput("abort_no_activity", seen, 0);

        $display("[TB] reset during write address phase");
        applyStimulus(8'h57, 1'b0);
        applyStimulus(8'h00, 1'b0); applyStimulus(8'h00, 1'b0);
        applyStimulus(8'h00, 1'b0); applyStimulus(8'h0C, 1'b0);
        applyStimulus(8'h00, 1'b0); applyStimulus(8'h00, 1'b0);
        applyStimulus(8'h00, 1'b0); applyStimulus(8'h05, 1'b0);
        checkOutput("mr_awvalid_before", awvalid, 1);
        #3 nrst = 0;
        #1;
        checkOutput("mr_valids", {awvalid, wvalid}, 0);
        checkOutput("mr_busy", busy, 0);
        #2 nrst = 1;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1 seen = seen | tx_start | bready | awvalid;
        end
        checkOutput("mr_no_pending", seen, 0);
        doRead(32'h0000_0030, 32'hCAFE_F00D, 2'b00);

        $display("[TB] partial frame then idle");
        applyStimulus(8'h52, 1'b0);
        applyStimulus(8'h00, 1'b0);
        checkOutput("to_busy_partial", busy, 1);
        repeat (110) @(posedge clk);
        #1;
`ifdef UART_AXIL_TIMEOUT_EN
        checkOutput("to_idle", busy, 0);
`else
        checkOutput("to_still_waiting", busy, 1);
        applyStimulus(8'h00, 1'b1);
        checkOutput("to_abort", busy, 0);
`endif
        checkOutput("to_no_arvalid", arvalid, 0);
        doRead(32'h0000_0044, 32'h0BAD_F00D, 2'b01);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/uart_axil_master.md
UART_AXIL_MASTER -- requirements
Module: uart_axil_master

Interface
REQ-001 Parameters SHALL be ADDR_WIDTH (default 32, AXI address width, 1..32) and TIMEOUT_CYCLES (default 5_000_000, inter-byte timeout in clk cycles).
REQ-002 Ports SHALL be: clk input 1 system clock; nrst input 1 reset (one clock; reset asynchronous, active-low).
REQ-003 Ports SHALL be: rx_data input 8 received byte; rx_valid input 1 one-cycle new-byte strobe; rx_error input 1 framing-error flag, sampled only when rx_valid=1.
REQ-004 Ports SHALL be: tx_data output 8 byte to send; tx_start output 1 transmit request; tx_done input 1 one-cycle byte-complete strobe.
REQ-005 Ports SHALL be: busy output 1, high from opcode accept until last response byte's tx_done.
REQ-006 AXI4-Lite master ports SHALL be m_axi_awaddr/awprot/awvalid out, awready in; m_axi_wdata(32)/wstrb(4)/wvalid out, wready in; m_axi_bresp(2)/bvalid in, bready out.
REQ-007 AXI4-Lite read ports SHALL be m_axi_araddr/arprot/arvalid out, arready in; m_axi_rdata(32)/rresp(2)/rvalid in, rready out.

Function
REQ-010 Command frame SHALL be: opcode byte, 4 address bytes MSB first, then for writes 4 data bytes MSB first; opcode 0x57 = write, 0x52 = read.
REQ-011 In IDLE, any other opcode byte SHALL be dropped with no response and no state change.
REQ-012 Address SHALL be the low ADDR_WIDTH bits of the 32-bit received value; awprot/arprot SHALL be 3'b000, wstrb SHALL be 4'hF.
REQ-013 FSM states SHALL be IDLE, GET_ADDR, GET_DATA, AXI_WR, AXI_B, AXI_AR, AXI_R, SEND_RESP; byte counter 0..3 per field.
REQ-014 AXI_WR SHALL assert awvalid and wvalid in the same cycle and drop each independently after its own valid&ready handshake; AXI_B SHALL be entered once both are done.
REQ-015 bready SHALL be high only in AXI_B; rready only in AXI_R; arvalid held in AXI_AR until arready; no valid SHALL drop before its handshake.
REQ-016 Write response SHALL be one byte {6'b0, bresp}; read response SHALL be {6'b0, rresp} followed by rdata MSB first (5 bytes).
REQ-017 tx_start and tx_data SHALL stay stable from assertion until tx_done; in the tx_done cycle tx_data SHALL switch to the next byte with tx_start kept high, or tx_start SHALL drop after the last byte.
REQ-018 rx_valid with rx_error=1 in GET_ADDR/GET_DATA SHALL abort the frame to IDLE with no AXI access; in IDLE it SHALL be ignored.
REQ-019 rx_valid in AXI_*/SEND_RESP states SHALL be discarded; busy tells the host to wait.
REQ-020 Latency SHALL be: first AXI valid asserted in the cycle after the last command byte's rx_valid; tx_start asserted in the cycle after bvalid/rvalid handshake.

Reset
REQ-030 During nrst=0, state SHALL be IDLE and all valids, bready, rready, tx_start and busy SHALL be 0; address, data and tx_data registers SHALL be 0.
REQ-031 Reset mid-transaction SHALL drop all AXI valids immediately (asynchronously); no pending response SHALL be sent after release.

Configuration
REQ-040 With UART_AXIL_TIMEOUT_EN defined, a counter SHALL clear on every rx_valid, and reaching TIMEOUT_CYCLES-1 in GET_ADDR/GET_DATA SHALL return to IDLE silently.
REQ-041 Without UART_AXIL_TIMEOUT_EN, no counter SHALL be built and a partial frame SHALL wait indefinitely.

Structure
REQ-050 Package uart_axil_pkg SHALL hold the state enum, OPC_WRITE=8'h57, OPC_READ=8'h52 and RESP_* byte-count constants.
REQ-051 Response serialisation (byte shift register, tx_start/tx_done handshake) SHALL be sub-module uart_axil_resp_ser; everything else in uart_axil_master.

Verification
REQ-060 Write 57 00 00 10 04 DE AD BE EF, awready/wready same cycle, bresp=0 -> awaddr=0x1004, wdata=0xDEADBEEF, tx byte 0x00.
REQ-061 Read 52 00 00 00 20, rdata=0x12345678, rresp=2 -> araddr=0x20, tx bytes 02 12 34 56 78 in order, busy low after 5th tx_done.
REQ-062 Write with wready 3 cycles after awready -> awvalid drops first, wvalid held, bready asserts only after both handshakes.
REQ-063 Bytes 41 then 52 00 rx_error=1 -> 0x41 dropped, frame aborted, no arvalid, no tx_start.
REQ-064 nrst pulsed while awvalid=1 and awready=0 -> awvalid, wvalid, busy 0 at once; next valid read frame completes normally.
REQ-065 UART_AXIL_TIMEOUT_EN, TIMEOUT_CYCLES=100: send 52 00, idle 100 cycles -> IDLE; fresh read frame succeeds.
